mem_rq_initiator: RTL
=====================

// Module: mem_rq_initiator
// PURPOSE
//   Initiator end of the 65-bit memory request / 32-bit response get/put interface.
//   Accepts one load/store at a time from a client on a valid/ready port and presents it as
//   obtain_rq_get = {addr[64:33], iswrite[32], data[31:0]} with RDY/EN, then collects the
//   single send_rs_put response. Sits between a client (test sequencer, DMA) and a RAM-style responder.
// PARAMETERS
//   TIMEOUT   64  cycles allowed from entering REQ to response before an error completion (>=2)
//   TW        $clog2(TIMEOUT+1)  width of timeout counter (derived; do not override)
// PORTS
//   clk                input   1   clock, all state on posedge
//   reset              input   1   asynchronous, active-high
//   cpu_req_valid      input   1   client request valid
//   cpu_req_ready      output  1   initiator can accept a request
//   cpu_req_addr       input   32  byte address (unaligned allowed, passed through)
//   cpu_req_iswrite    input   1   1 = store, 0 = load
//   cpu_req_data       input   32  store data (ignored for loads)
//   cpu_rsp_valid      output  1   completion valid
//   cpu_rsp_ready      input   1   client accepts completion
//   cpu_rsp_data       output  32  load data; 0 for stores and errors
//   cpu_rsp_err        output  1   1 = timeout completion
//   obtain_rq_get      output  65  {addr, iswrite, data} of the pending request
//   rdy_obtain_rq_get  output  1   request available to responder
//   en_obtain_rq_get   input   1   responder takes request this cycle
//   send_rs_put        input   32  response data (only meaningful when en_send_rs_put)
//   en_send_rs_put     input   1   responder delivers response this cycle
//   rdy_send_rs_put    output  1   initiator can take a response
//   stray_rs           output  1   sticky: response arrived while not in WAIT; cleared only by reset
// BEHAVIOUR
//   Reset (async assert, sync deassert): state=IDLE; every output 0 incl. cpu_req_ready,
//     obtain_rq_get, stray_rs. Cycle after release cpu_req_ready=1. Reset mid-transaction drops it;
//     no completion is ever produced for it.
//   FSM IDLE -> REQ -> WAIT -> RESP -> IDLE. Outputs decoded from state only (Moore).
//   IDLE: cpu_req_ready=1. valid&ready: register addr/iswrite/data (data forced 0 for loads),
//     clear timer, -> REQ.
//   REQ: rdy_obtain_rq_get=1, obtain_rq_get=registered fields, stable until taken.
//     en_obtain_rq_get -> WAIT. Responder may assert EN in the first REQ cycle.
//   WAIT: rdy_send_rs_put=1. en_send_rs_put: capture send_rs_put (loads) or 0 (stores), err=0, -> RESP.
//     Every request, store included, receives exactly one response.
//   Timer: counts every cycle in REQ and WAIT, saturates at TIMEOUT. On reaching TIMEOUT
//     -> RESP with err=1, data=0. Response EN in the expiry cycle wins (err=0).
//     Timeout in REQ withdraws the request (rdy_obtain_rq_get drops).
//   RESP: cpu_rsp_valid=1, data/err stable until cpu_rsp_ready; then -> IDLE.
//     No new request accepted in the same cycle (no bypass).
//   Ignored inputs: en_obtain_rq_get outside REQ; en_send_rs_put outside WAIT (sets stray_rs);
//     send_rs_put never sampled without en_send_rs_put (X-tolerant).
//   Latency with a responder that takes the request immediately and responds the next cycle:
//     req handshake cycle N; rdy_obtain N+1; response N+2; cpu_rsp_valid N+3.
//     Throughput: one transaction per 4 cycles minimum.
// TESTING
//   Load: addr=0x10, iswrite=0 -> obtain_rq_get=={32'h10,1'b0,32'h0}; resp 0xDEADBEEF -> cpu_rsp_data=0xDEADBEEF, err=0, valid at N+3.
//   Store: addr=0x3, data=0xA5A5_0001, iswrite=1 -> obtain_rq_get=={32'h3,1'b1,32'hA5A50001}; resp 0x1234 -> cpu_rsp_data=0, err=0.
//   Timeout: EN never asserted, TIMEOUT=8 -> rdy_obtain drops; cpu_rsp_valid with err=1 exactly 8 cycles after REQ entry.
//   Backpressure: cpu_rsp_ready low 5 cycles -> rsp held stable, cpu_req_ready=0; stray en_send_rs_put then -> stray_rs=1.
//   Async reset in WAIT -> outputs 0 same cycle, no cpu_rsp_valid after release; next load completes normally.
//   Race: en_send_rs_put on timer expiry cycle -> err=0, captured data returned.

Source files
------------

// File: rtl/mem_rq_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_rq_initiator_if
// Purpose  : Bundles the client request/completion port and the responder
//            get/put port of mem_rq_initiator.
//            master = initiator view, slave = client + responder view.
// Signals  : cpu_req_*         client request (valid/ready)
//            cpu_rsp_*         client completion (valid/ready)
//            obtain_rq_get     {addr[64:33], iswrite[32], data[31:0]}
//            rdy/en_obtain_*   request get handshake
//            send_rs_put       response data
//            rdy/en_send_*     response put handshake
//            stray_rs          sticky unexpected-response flag
// Revision : 1.0 - initial release
// ============================================================================
interface mem_rq_initiator_if;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [31:0] cpu_req_addr;
    logic        cpu_req_iswrite;
    logic [31:0] cpu_req_data;
    logic        cpu_rsp_valid;
    logic        cpu_rsp_ready;
    logic [31:0] cpu_rsp_data;
    logic        cpu_rsp_err;
    logic [64:0] obtain_rq_get;
    logic        rdy_obtain_rq_get;
    logic        en_obtain_rq_get;
    logic [31:0] send_rs_put;
    logic        en_send_rs_put;
    logic        rdy_send_rs_put;
    logic        stray_rs;

    modport master (
        input  cpu_req_valid, cpu_req_addr, cpu_req_iswrite, cpu_req_data,
        input  cpu_rsp_ready, en_obtain_rq_get, send_rs_put, en_send_rs_put,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, cpu_rsp_err,
        output obtain_rq_get, rdy_obtain_rq_get, rdy_send_rs_put, stray_rs
    );

    modport slave (
        output cpu_req_valid, cpu_req_addr, cpu_req_iswrite, cpu_req_data,
        output cpu_rsp_ready, en_obtain_rq_get, send_rs_put, en_send_rs_put,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, cpu_rsp_err,
        input  obtain_rq_get, rdy_obtain_rq_get, rdy_send_rs_put, stray_rs
    );
endinterface
`default_nettype wire

// File: rtl/mem_rq_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_rq_initiator
// Purpose  : Initiator end of the 65-bit request / 32-bit response get/put
//            interface. Takes one load/store at a time from a client,
//            offers it to the responder, collects exactly one response (or
//            times out) and returns a completion to the client.
// Ports    : clk    - clock, all state on posedge
//            reset  - asynchronous, active-high
//            bus    - mem_rq_initiator_if.master (client + responder ports)
// Params   : TIMEOUT - cycles from REQ entry to error completion (>=2)
// Revision : 1.0 - initial release
// ============================================================================
module mem_rq_initiator #(
    parameter int TIMEOUT = 64
) (
    input  wire logic            clk,
    input  wire logic            reset,
    mem_rq_initiator_if.master   bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [64:0]     req_q, req_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            stray_q, stray_d;
    logic            cpu_req_ready_q, cpu_req_ready_d;
    logic            cpu_rsp_valid_q, cpu_rsp_valid_d;
    logic            rdy_obtain_q, rdy_obtain_d;
    logic            rdy_send_q, rdy_send_d;
    logic            expire;

    // The timer is zero in the first REQ cycle, so it reads TIMEOUT-1 in
    // the last cycle before the error completion becomes visible; this makes
    // cpu_rsp_valid rise exactly TIMEOUT cycles after REQ entry.
    assign expire = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        req_d      = req_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        if (((state_q == ST_REQ) || (state_q == ST_WAIT)) &&
            (timer_q != TW'(TIMEOUT))) begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // Handshake uses the registered ready, which stays low for
                // the first cycle after reset release.
                if (bus.cpu_req_valid && cpu_req_ready_q) begin
                    req_d   = {bus.cpu_req_addr, bus.cpu_req_iswrite,
                               bus.cpu_req_iswrite ? bus.cpu_req_data : 32'h0};
                    timer_d = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Expiry withdraws the request even if the responder takes it
                // in the same cycle.
                if (expire) begin
                    rsp_data_d = 32'h0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else if (bus.en_obtain_rq_get) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response in the expiry cycle beats the timeout.
                if (bus.en_send_rs_put) begin
                    rsp_data_d = req_q[32] ? 32'h0 : bus.send_rs_put;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (expire) begin
                    rsp_data_d = 32'h0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            default: begin
                if (bus.cpu_rsp_ready && cpu_rsp_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        stray_d = stray_q | (bus.en_send_rs_put && (state_q != ST_WAIT));

        // Moore outputs registered from the next state so that all of them
        // are held at zero throughout reset.
        cpu_req_ready_d = (state_d == ST_IDLE);
        cpu_rsp_valid_d = (state_d == ST_RESP);
        rdy_obtain_d    = (state_d == ST_REQ);
        rdy_send_d      = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            timer_q         <= '0;
            req_q           <= '0;
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b0;
            stray_q         <= 1'b0;
            cpu_req_ready_q <= 1'b0;
            cpu_rsp_valid_q <= 1'b0;
            rdy_obtain_q    <= 1'b0;
            rdy_send_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            req_q           <= req_d;
            rsp_data_q      <= rsp_data_d;
            rsp_err_q       <= rsp_err_d;
            stray_q         <= stray_d;
            cpu_req_ready_q <= cpu_req_ready_d;
            cpu_rsp_valid_q <= cpu_rsp_valid_d;
            rdy_obtain_q    <= rdy_obtain_d;
            rdy_send_q      <= rdy_send_d;
        end
    end

    assign bus.cpu_req_ready     = cpu_req_ready_q;
    assign bus.cpu_rsp_valid     = cpu_rsp_valid_q;
    assign bus.cpu_rsp_data      = rsp_data_q;
    assign bus.cpu_rsp_err       = rsp_err_q;
    assign bus.obtain_rq_get     = req_q;
    assign bus.rdy_obtain_rq_get = rdy_obtain_q;
    assign bus.rdy_send_rs_put   = rdy_send_q;
    assign bus.stray_rs          = stray_q;

endmodule
`default_nettype wire
